// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and load-type encodings.
package cpu_pkg;

    localparam int DW = 32;
    localparam int AW = 5;

    // Encodings 6 and 7 are not listed here and behave like LT_NONE.
    typedef enum logic [2:0] {
        LT_NONE = 3'd0,
        LT_LB   = 3'd1,
        LT_LBU  = 3'd2,
        LT_LH   = 3'd3,
        LT_LHU  = 3'd4,
        LT_LW   = 3'd5
    } load_type_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Memory-stage to write-back handshake bus: instruction payload plus valid/ready.
interface mem_wb_stage_if
    import cpu_pkg::*;
#(
    parameter int DW = cpu_pkg::DW,
    parameter int AW = cpu_pkg::AW
);
    logic          in_valid;
    logic          in_ready;
    logic          in_we;
    logic [AW-1:0] in_waddr;
    logic [DW-1:0] in_alu;
    logic [DW-1:0] in_rdata;
    logic [2:0]    in_load_type;
    logic [1:0]    in_off;
    logic          in_hilo_we;
    logic [DW-1:0] in_hi;
    logic [DW-1:0] in_lo;

    modport master (
        output in_valid, in_we, in_waddr, in_alu, in_rdata,
               in_load_type, in_off, in_hilo_we, in_hi, in_lo,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_we, in_waddr, in_alu, in_rdata,
               in_load_type, in_off, in_hilo_we, in_hi, in_lo,
        output in_ready
    );
endinterface

// File: rtl/mem_wb_stage_load_align.sv
// Combinational load-data extraction/extension with misalignment detection.
module load_align
    import cpu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  load_type,
    input  logic [31:0] alu,
    output logic [31:0] data,
    output logic        misalign
);
    logic [7:0]  bsel;
    logic [15:0] hsel;
    load_type_e  lt;

    assign bsel = rdata[{off, 3'b000} +: 8];
    assign hsel = off[1] ? rdata[31:16] : rdata[15:0];
    assign lt   = load_type_e'(load_type);

    always_comb begin
        data     = alu;
        misalign = 1'b0;
        case (lt)
            LT_LB:  data = {{24{bsel[7]}}, bsel};
            LT_LBU: data = {24'h000000, bsel};
            LT_LH: begin
                data     = {{16{hsel[15]}}, hsel};
                misalign = off[0];
            end
            LT_LHU: begin
                data     = {16'h0000, hsel};
                misalign = off[0];
            end
            LT_LW: begin
                data     = rdata;
                misalign = (off != 2'b00);
            end
            default: data = alu;
        endcase
    end
endmodule

// File: rtl/mem_wb_stage.sv
// Memory/write-back stage: holds one instruction, drives the regfile write port,
// maintains HI/LO and a retire counter.
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int DW    = cpu_pkg::DW,
    parameter int AW    = cpu_pkg::AW,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    mem_wb_stage_if.slave    m,
    input  logic             hold,
    input  logic             flush,
    output logic             we,
    output logic [AW-1:0]    wAddr,
    output logic [DW-1:0]    wData,
    output logic [DW-1:0]    hi,
    output logic [DW-1:0]    lo,
    output logic             fwd_valid,
    output logic [AW-1:0]    fwd_addr,
    output logic [DW-1:0]    fwd_data,
    output logic             addr_err,
    output logic [CNT_W-1:0] retire_cnt
);
    logic          valid_q;
    logic          we_q;
    logic [AW-1:0] waddr_q;
    logic [DW-1:0] alu_q;
    logic [DW-1:0] rdata_q;
    logic [2:0]    load_type_q;
    logic [1:0]    off_q;
    logic          hilo_we_q;
    logic [DW-1:0] hi_q;
    logic [DW-1:0] lo_q;

    logic          capture;
    logic          retire;
    logic [DW-1:0] ld_data;
    logic          misalign;

    assign m.in_ready = !valid_q | !hold;
    assign capture    = m.in_valid & m.in_ready;
    // A flushed instruction never retires, so it is masked from every side effect.
    assign retire     = valid_q & !hold & !flush;

    load_align u_load_align (
        .rdata     (rdata_q),
        .off       (off_q),
        .load_type (load_type_q),
        .alu       (alu_q),
        .data      (ld_data),
        .misalign  (misalign)
    );

    assign we        = retire & we_q & (waddr_q != '0) & !misalign;
    assign wAddr     = waddr_q;
    assign wData     = ld_data;
    assign addr_err  = retire & misalign;
    assign fwd_valid = we;
    assign fwd_addr  = wAddr;
    assign fwd_data  = wData;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            alu_q       <= '0;
            rdata_q     <= '0;
            load_type_q <= '0;
            off_q       <= '0;
            hilo_we_q   <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            hi          <= '0;
            lo          <= '0;
            retire_cnt  <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (capture) begin
                valid_q     <= 1'b1;
                we_q        <= m.in_we;
                waddr_q     <= m.in_waddr;
                alu_q       <= m.in_alu;
                rdata_q     <= m.in_rdata;
                load_type_q <= m.in_load_type;
                off_q       <= m.in_off;
                hilo_we_q   <= m.in_hilo_we;
                hi_q        <= m.in_hi;
                lo_q        <= m.in_lo;
            end else if (!hold) begin
                valid_q <= 1'b0;
            end

            if (retire) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
                if (hilo_we_q) begin
                    hi <= hi_q;
                    lo <= lo_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed literal cases plus randomized traffic
// compared every cycle against a behavioural model.
module tb_mem_wb_stage;

    typedef struct {
        bit          we;
        logic [4:0]  waddr;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [2:0]  lt;
        logic [1:0]  off;
        bit          hilo_we;
        logic [31:0] hi;
        logic [31:0] lo;
    } instr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold, flush;
    logic        we, fwd_valid, addr_err;
    logic [4:0]  wAddr, fwd_addr;
    logic [31:0] wData, fwd_data, hi, lo, retire_cnt;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state: one slot of held instruction plus architectural HI/LO/count.
    bit          m_valid;
    instr_t      m_ins;
    logic [31:0] m_hi, m_lo, m_cnt;

    instr_t idle_i;

    mem_wb_stage_if #(.DW(32), .AW(5)) bus ();

    mem_wb_stage #(.DW(32), .AW(5), .CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .m          (bus.slave),
        .hold       (hold),
        .flush      (flush),
        .we         (we),
        .wAddr      (wAddr),
        .wData      (wData),
        .hi         (hi),
        .lo         (lo),
        .fwd_valid  (fwd_valid),
        .fwd_addr   (fwd_addr),
        .fwd_data   (fwd_data),
        .addr_err   (addr_err),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input instr_t x, output bit mis);
        int unsigned b, h;
        b   = (x.rdata >> (8 * x.off)) & 32'hFF;
        h   = (x.rdata >> (16 * (x.off / 2))) & 32'hFFFF;
        mis = 1'b0;
        case (int'(x.lt))
            1: return (b >= 128) ? 32'(b) + 32'hFFFF_FF00 : 32'(b);
            2: return 32'(b);
            3: begin mis = (x.off % 2) == 1; return (h >= 32768) ? 32'(h) + 32'hFFFF_0000 : 32'(h); end
            4: begin mis = (x.off % 2) == 1; return 32'(h); end
            5: begin mis = (x.off != 0); return x.rdata; end
            default: return x.alu;
        endcase
    endfunction

    task automatic drive(input instr_t x, input bit v, input bit h, input bit f);
        bus.in_valid     = v;
        bus.in_we        = x.we;
        bus.in_waddr     = x.waddr;
        bus.in_alu       = x.alu;
        bus.in_rdata     = x.rdata;
        bus.in_load_type = x.lt;
        bus.in_off       = x.off;
        bus.in_hilo_we   = x.hilo_we;
        bus.in_hi        = x.hi;
        bus.in_lo        = x.lo;
        hold             = h;
        flush            = f;
        #1;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_ins   = idle_i;
        m_hi    = '0;
        m_lo    = '0;
        m_cnt   = '0;
    endtask

    // Compare the DUT against the model for the current inputs, then advance one clock.
    task automatic tick();
        bit          ret, mis, exp_we, ready;
        logic [31:0] d;
        bit          n_valid;
        instr_t      n_ins;
        ready  = !m_valid || !hold;
        ret    = m_valid && !hold && !flush;
        d      = ref_load(m_ins, mis);
        exp_we = ret && m_ins.we && (m_ins.waddr != 0) && !mis;
        check("in_ready", {31'b0, bus.in_ready}, {31'b0, ready});
        check("we", {31'b0, we}, {31'b0, exp_we});
        check("fwd_valid", {31'b0, fwd_valid}, {31'b0, exp_we});
        check("addr_err", {31'b0, addr_err}, {31'b0, ret && mis});
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
        check("retire_cnt", retire_cnt, m_cnt);
        if (exp_we) begin
            check("wAddr", {27'b0, wAddr}, {27'b0, m_ins.waddr});
            check("wData", wData, d);
            check("fwd_addr", {27'b0, fwd_addr}, {27'b0, m_ins.waddr});
            check("fwd_data", fwd_data, d);
        end

        n_valid = m_valid;
        n_ins   = m_ins;
        if (flush) n_valid = 1'b0;
        else if (bus.in_valid && ready) begin
            n_valid          = 1'b1;
            n_ins.we         = bus.in_we;
            n_ins.waddr      = bus.in_waddr;
            n_ins.alu        = bus.in_alu;
            n_ins.rdata      = bus.in_rdata;
            n_ins.lt         = bus.in_load_type;
            n_ins.off        = bus.in_off;
            n_ins.hilo_we    = bus.in_hilo_we;
            n_ins.hi         = bus.in_hi;
            n_ins.lo         = bus.in_lo;
        end else if (!hold) n_valid = 1'b0;

        @(posedge clk);
        if (ret) begin
            m_cnt = m_cnt + 1;
            if (m_ins.hilo_we) begin
                m_hi = m_ins.hi;
                m_lo = m_ins.lo;
            end
        end
        m_valid = n_valid;
        m_ins   = n_ins;
        #1;
    endtask

    function automatic instr_t mk(input bit w, input int a, input logic [31:0] alu,
                                  input logic [31:0] rd, input int lt, input int off);
        instr_t x;
        x         = '{default: '0};
        x.we      = w;
        x.waddr   = 5'(a);
        x.alu     = alu;
        x.rdata   = rd;
        x.lt      = 3'(lt);
        x.off     = 2'(off);
        return x;
    endfunction

    initial begin
        int          ld_lt  [5] = '{1, 2, 3, 4, 5};
        int          ld_off [5] = '{3, 3, 2, 0, 0};
        logic [31:0] ld_exp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                                    32'h0000_7F01, 32'h80FF_7F01};
        instr_t x;

        idle_i = '{default: '0};
        rst = 1'b1;
        drive(idle_i, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check("reset_we", {31'b0, we}, 32'd0);
        check("reset_wData", wData, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_cnt", retire_cnt, 32'd0);
        check("reset_ready", {31'b0, bus.in_ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Plain ALU write
        drive(mk(1, 8, 32'h1234_5678, 32'h0, 0, 0), 1, 0, 0);
        tick();
        drive(idle_i, 0, 0, 0);
        check("alu_we", {31'b0, we}, 32'd1);
        check("alu_wAddr", {27'b0, wAddr}, 32'd8);
        check("alu_wData", wData, 32'h1234_5678);
        tick();
        check("alu_cnt", retire_cnt, 32'd1);

        // Load extraction on 0x80FF7F01
        for (int i = 0; i < 5; i++) begin
            drive(mk(1, 3, 32'hDEAD_BEEF, 32'h80FF_7F01, ld_lt[i], ld_off[i]), 1, 0, 0);
            tick();
            drive(idle_i, 0, 0, 0);
            check($sformatf("load%0d_data", i), wData, ld_exp[i]);
            check($sformatf("load%0d_we", i), {31'b0, we}, 32'd1);
            tick();
        end

        // Misaligned LW
        drive(mk(1, 4, 32'h0, 32'h1111_2222, 5, 1), 1, 0, 0);
        tick();
        drive(idle_i, 0, 0, 0);
        check("mis_we", {31'b0, we}, 32'd0);
        check("mis_err", {31'b0, addr_err}, 32'd1);
        tick();
        check("mis_err_pulse", {31'b0, addr_err}, 32'd0);
        check("mis_cnt", retire_cnt, 32'd7);

        // HI/LO write targeting r0
        x = mk(1, 0, 32'h5, 32'h0, 0, 0);
        x.hilo_we = 1'b1; x.hi = 32'hA; x.lo = 32'hB;
        drive(x, 1, 0, 0);
        tick();
        drive(idle_i, 0, 0, 0);
        check("r0_we", {31'b0, we}, 32'd0);
        tick();
        check("hilo_hi", hi, 32'hA);
        check("hilo_lo", lo, 32'hB);
        check("hilo_cnt", retire_cnt, 32'd8);

        // Hold for three cycles
        drive(mk(1, 9, 32'hCAFE_0009, 32'h0, 0, 0), 1, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(mk(1, 12, 32'h0BAD_0BAD, 32'h0, 0, 0), 1, 1, 0);
            check("hold_ready", {31'b0, bus.in_ready}, 32'd0);
            check("hold_we", {31'b0, we}, 32'd0);
            tick();
        end
        drive(idle_i, 0, 0, 0);
        check("release_we", {31'b0, we}, 32'd1);
        check("release_wAddr", {27'b0, wAddr}, 32'd9);
        check("release_wData", wData, 32'hCAFE_0009);
        tick();
        check("release_once", {31'b0, we}, 32'd0);
        check("release_cnt", retire_cnt, 32'd9);

        // Flush in the same cycle as a capture
        drive(mk(1, 10, 32'h7777_7777, 32'h0, 0, 0), 1, 0, 1);
        tick();
        drive(idle_i, 0, 0, 0);
        check("flush_we", {31'b0, we}, 32'd0);
        tick();
        check("flush_cnt", retire_cnt, 32'd9);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            x.we      = $urandom_range(0, 3) != 0;
            x.waddr   = 5'($urandom_range(0, 31));
            x.alu     = $urandom;
            x.rdata   = $urandom;
            x.lt      = 3'($urandom_range(0, 7));
            x.off     = 2'($urandom_range(0, 3));
            x.hilo_we = $urandom_range(0, 2) == 0;
            x.hi      = $urandom;
            x.lo      = $urandom;
            drive(x, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0);
            tick();
        end

        // Asynchronous reset while an instruction is held
        x = mk(1, 6, 32'h0, 32'h0, 0, 0);
        x.hilo_we = 1'b1; x.hi = 32'h55; x.lo = 32'h66;
        drive(x, 1, 0, 0);
        tick();
        drive(mk(1, 5, 32'h1, 32'h0, 0, 0), 1, 0, 0);
        tick();
        drive(mk(1, 5, 32'h2, 32'h0, 0, 0), 1, 1, 0);
        tick();
        check("pre_rst_hi", hi, 32'h55);
        #2;
        rst = 1'b1;
        #1;
        check("rst_we", {31'b0, we}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_cnt", retire_cnt, 32'd0);
        model_reset();
        #3;
        rst = 1'b0;
        drive(idle_i, 0, 0, 0);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
